// File: rtl/counter_serializer_pkg.sv
// Shared types and line levels for the counter serializer.
// The FSM encoding and frame constants live here so the FSM and the bench agree on them.
package counter_serial_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} ser_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // Counter width that stays at least 1 bit when the range is a single value
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/counter_serializer_if.sv
// Capture/serial-line bundle between the display counter side and the serializer.
interface counter_serializer_if #(
    parameter int DATA_WIDTH = 4,
    parameter int FIFO_DEPTH = 4
);
    logic [DATA_WIDTH-1:0]       ValueIn;
    logic                        ValueValid;
    logic                        SerialOut;
    logic                        Busy;
    logic [$clog2(FIFO_DEPTH):0] FifoCount;
    logic                        Overflow;

    modport master (
        output ValueIn, ValueValid,
        input  SerialOut, Busy, FifoCount, Overflow
    );

    modport slave (
        input  ValueIn, ValueValid,
        output SerialOut, Busy, FifoCount, Overflow
    );
endinterface

// File: rtl/counter_serializer_sync_fifo.sv
// Small synchronous FIFO with a combinational head read.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int DATA_WIDTH = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        ClockIn,
    input  logic                        Reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic [DATA_WIDTH-1:0]       din,
    output logic [DATA_WIDTH-1:0]       dout,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        full,
    output logic                        empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge ClockIn) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/counter_serializer.sv
// Captures counter values into a FIFO and sends each as a start/data(MSB first)/stop frame
// on SerialOut, with back-to-back frames when more values are queued.
module counter_serializer
    import counter_serial_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 4,
    parameter int DATA_WIDTH     = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input logic               ClockIn,
    input logic               Reset,
    counter_serializer_if.slave bus
);
    localparam int unsigned CW = cnt_width(CLOCKS_PER_BIT);
    localparam int unsigned BW = cnt_width(DATA_WIDTH);
    localparam int          AW = $clog2(FIFO_DEPTH);

    ser_state_t            state;
    logic [CW-1:0]         cyc;
    logic [BW-1:0]         bitn;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] shift_nx;
    logic [DATA_WIDTH-1:0] head;
    logic [AW:0]           fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  bit_end;
    logic                  pop;

    assign bit_end  = (cyc == CW'(CLOCKS_PER_BIT - 1));
    assign shift_nx = shift << 1;
    // Pop in IDLE or on the last STOP cycle so the next frame starts with no idle gap
    assign pop = !fifo_empty && ((state == IDLE) || (state == STOP && bit_end));

    sync_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .ClockIn(ClockIn),
        .Reset  (Reset),
        .push   (bus.ValueValid),
        .pop    (pop),
        .din    (bus.ValueIn),
        .dout   (head),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign bus.FifoCount = fifo_count;

    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            state         <= IDLE;
            cyc           <= '0;
            bitn          <= '0;
            shift         <= '0;
            bus.SerialOut <= IDLE_LEVEL;
            bus.Busy      <= 1'b0;
            bus.Overflow  <= 1'b0;
        end else begin
            if (bus.ValueValid && fifo_full && !pop) bus.Overflow <= 1'b1;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        shift         <= head;
                        cyc           <= '0;
                        state         <= START;
                        bus.SerialOut <= START_BIT;
                        bus.Busy      <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cyc           <= '0;
                        bitn          <= '0;
                        state         <= DATA;
                        bus.SerialOut <= shift[DATA_WIDTH-1];
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cyc <= '0;
                        if (bitn == BW'(DATA_WIDTH - 1)) begin
                            state         <= STOP;
                            bus.SerialOut <= STOP_BIT;
                        end else begin
                            bitn          <= bitn + 1'b1;
                            shift         <= shift_nx;
                            bus.SerialOut <= shift_nx[DATA_WIDTH-1];
                        end
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cyc <= '0;
                        if (!fifo_empty) begin
                            shift         <= head;
                            state         <= START;
                            bus.SerialOut <= START_BIT;
                        end else begin
                            state    <= IDLE;
                            bus.Busy <= 1'b0;
                        end
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_counter_serializer.sv
// Self-checking bench: a serial-line monitor decodes frames and compares them against
// a scoreboard of accepted pushes, plus directed latency, gap, overflow and reset checks.
module tb_counter_serializer;
    localparam int CPB   = 4;
    localparam int DW    = 4;
    localparam int FD    = 4;
    localparam int FRAME = (DW + 2) * CPB;

    logic ClockIn = 1'b0;
    logic Reset;
    always #5 ClockIn = ~ClockIn;

    counter_serializer_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) bus ();

    counter_serializer #(
        .CLOCKS_PER_BIT(CPB),
        .DATA_WIDTH    (DW),
        .FIFO_DEPTH    (FD)
    ) dut (
        .ClockIn(ClockIn),
        .Reset  (Reset),
        .bus    (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;

    logic [DW-1:0] sb[$];
    int unsigned   starts[$];
    int            peak = 0;

    always @(posedge ClockIn) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Frame monitor: samples the middle of each bit period
    bit          in_frame = 1'b0;
    int          pos;
    logic [DW-1:0] rx;
    always @(negedge ClockIn) begin
        if (Reset) begin
            in_frame = 1'b0;
        end else begin
            if (int'(bus.FifoCount) > peak) peak = int'(bus.FifoCount);
            if (!in_frame && bus.SerialOut == 1'b0) begin
                in_frame = 1'b1;
                pos      = 0;
                rx       = '0;
                starts.push_back(cyc);
            end
            if (in_frame) begin
                if (pos % CPB == CPB / 2) begin
                    check_eq("busy_in_frame", bus.Busy, 1);
                    if (pos / CPB == 0) begin
                        check_eq("start_bit", bus.SerialOut, 0);
                    end else if (pos / CPB <= DW) begin
                        rx = {rx[DW-2:0], bus.SerialOut};
                    end else begin
                        check_eq("stop_bit", bus.SerialOut, 1);
                        check_eq("frame_expected", sb.size() > 0, 1);
                        if (sb.size() > 0) check_eq("frame_data", rx, sb.pop_front());
                    end
                end
                pos++;
                if (pos == FRAME) in_frame = 1'b0;
            end
        end
    end

    task automatic push_one(input logic [DW-1:0] v, input bit accepted);
        @(posedge ClockIn);
        #1;
        bus.ValueValid = 1'b1;
        bus.ValueIn    = v;
        if (accepted) sb.push_back(v);
    endtask

    task automatic end_push();
        @(posedge ClockIn);
        #1;
        bus.ValueValid = 1'b0;
        bus.ValueIn    = '0;
    endtask

    task automatic apply_reset();
        @(posedge ClockIn);
        #1;
        Reset = 1'b1;
        sb.delete();
        @(posedge ClockIn);
        #1;
        Reset = 1'b0;
        starts.delete();
        peak = 0;
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge ClockIn);
            if (sb.size() == 0 && !bus.Busy) break;
        end
        check_eq("drain_scoreboard", sb.size(), 0);
        check_eq("drain_idle", bus.Busy, 0);
    endtask

    initial begin
        int unsigned k;
        int          p;
        logic        exp_line;
        logic [DW-1:0] val;

        Reset          = 1'b1;
        bus.ValueValid = 1'b0;
        bus.ValueIn    = '0;
        repeat (3) @(posedge ClockIn);
        #1;
        Reset = 1'b0;

        // Quiet line after reset
        for (int i = 0; i < 50; i++) begin
            @(negedge ClockIn);
            check_eq("idle_serial", bus.SerialOut, 1);
            check_eq("idle_busy", bus.Busy, 0);
            check_eq("idle_count", bus.FifoCount, 0);
            check_eq("idle_overflow", bus.Overflow, 0);
        end

        // Single frame: exact cycle-by-cycle line and Busy window
        val = 4'hA;
        push_one(val, 1'b1);
        k = cyc;
        end_push();
        for (int i = 0; i < FRAME + 16; i++) begin
            @(negedge ClockIn);
            p = int'(cyc) - int'(k) - 2;
            if (p < 0 || p >= FRAME)   exp_line = 1'b1;
            else if (p / CPB == 0)     exp_line = 1'b0;
            else if (p / CPB <= DW)    exp_line = val[DW - p / CPB];
            else                       exp_line = 1'b1;
            check_eq("single_line", bus.SerialOut, exp_line);
            check_eq("single_busy", bus.Busy, (p >= 0 && p < FRAME));
        end
        check_eq("single_latency", starts[0] - k, 2);
        check_eq("single_drained", sb.size(), 0);

        // Three back-to-back frames
        starts.delete();
        peak = 0;
        push_one(4'h3, 1'b1);
        push_one(4'h7, 1'b1);
        push_one(4'hC, 1'b1);
        end_push();
        wait_drain(200);
        check_eq("b2b_frames", starts.size(), 3);
        if (starts.size() == 3) begin
            check_eq("b2b_gap1", starts[1] - starts[0], FRAME);
            check_eq("b2b_gap2", starts[2] - starts[1], FRAME);
        end
        check_eq("b2b_peak", peak, 2);

        // Six pushes: one popped, four queued, sixth dropped
        starts.delete();
        peak = 0;
        for (int i = 0; i < 6; i++) push_one(DW'(i + 1), i < 5);
        end_push();
        @(negedge ClockIn);
        check_eq("ovf_set", bus.Overflow, 1);
        wait_drain(400);
        check_eq("ovf_frames", starts.size(), 5);
        check_eq("ovf_peak", peak, 4);
        repeat (10) @(negedge ClockIn);
        check_eq("ovf_sticky", bus.Overflow, 1);

        // Full FIFO plus a push landing on the STOP->START pop
        apply_reset();
        check_eq("rst_overflow", bus.Overflow, 0);
        push_one(4'h5, 1'b1);
        k = cyc;
        for (int i = 1; i < 5; i++) push_one(DW'(4'h8 + i), 1'b1);
        end_push();
        while (cyc != k + 25) begin
            @(posedge ClockIn);
            #1;
        end
        check_eq("full_before", bus.FifoCount, 4);
        bus.ValueValid = 1'b1;
        bus.ValueIn    = 4'hF;
        sb.push_back(4'hF);
        @(posedge ClockIn);
        #1;
        bus.ValueValid = 1'b0;
        check_eq("full_after", bus.FifoCount, 4);
        check_eq("full_no_overflow", bus.Overflow, 0);
        wait_drain(600);
        check_eq("full_frames", starts.size(), 6);
        if (starts.size() == 6) check_eq("full_gap", starts[1] - starts[0], FRAME);
        check_eq("full_overflow_end", bus.Overflow, 0);

        // Reset during the data bits of frame 2 of 3
        apply_reset();
        push_one(4'h1, 1'b1);
        push_one(4'h2, 1'b1);
        push_one(4'h4, 1'b1);
        end_push();
        for (int i = 0; i < 200 && starts.size() < 2; i++) @(posedge ClockIn);
        check_eq("frame2_seen", starts.size(), 2);
        repeat (8) @(posedge ClockIn);
        #2;
        Reset = 1'b1;
        #1;
        check_eq("midrst_serial", bus.SerialOut, 1);
        check_eq("midrst_busy", bus.Busy, 0);
        check_eq("midrst_count", bus.FifoCount, 0);
        sb.delete();
        @(posedge ClockIn);
        #1;
        Reset = 1'b0;
        repeat (100) @(negedge ClockIn);
        check_eq("postrst_frames", starts.size(), 2);
        check_eq("postrst_count", bus.FifoCount, 0);
        check_eq("postrst_serial", bus.SerialOut, 1);
        check_eq("postrst_busy", bus.Busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule
